// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared encodings for the multdiv issue sequencer: FSM states, op kinds,
// exception codes and the writeback payload.
package multdiv_issue_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_kind_e;

  localparam logic [REG_W-1:0] RSTATUS_REG = REG_W'(30);
  localparam logic [XLEN-1:0]  EXC_MULT    = XLEN'(4);
  localparam logic [XLEN-1:0]  EXC_DIV     = XLEN'(5);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic             exc;
  } wb_t;

  // Writeback that reports a failed op through $rstatus.
  function automatic wb_t exc_wb(input op_kind_e kind);
    wb_t w;
    w.rd   = RSTATUS_REG;
    w.data = (kind == OP_MULT) ? EXC_MULT : EXC_DIV;
    w.exc  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_md_watchdog.sv
// Saturating BUSY-cycle counter; tc_c flags the last allowed BUSY cycle.
module md_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = en & (count == LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues mult/div from execute to the shared multdiv unit, stalls the front
// end while it runs, and emits a single writeback (result or $rstatus code).
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x_is_mult,
  input  logic             x_is_div,
  input  logic [XLEN-1:0]  x_opA,
  input  logic [XLEN-1:0]  x_opB,
  input  logic [REG_W-1:0] x_rd,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [XLEN-1:0]  md_opA,
  output logic [XLEN-1:0]  md_opB,
  input  logic [XLEN-1:0]  md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_exception
);

  logic [1:0]       state, state_nxt;
  op_kind_e         op, op_nxt;
  logic [XLEN-1:0]  opa_nxt, opb_nxt;
  logic [REG_W-1:0] rd_q, rd_nxt;
  logic             armed, armed_nxt;
  wb_t              wb_q, wb_nxt;
  logic             detect;
  logic             wd_tc_c;

  assign detect = x_valid & (x_is_mult | x_is_div);

  md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clr   (state == ST_ISSUE),
    .en    (state == ST_BUSY),
    .tc_c  (wd_tc_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op     <= OP_MULT;
      md_opA <= '0;
      md_opB <= '0;
      rd_q   <= '0;
      armed  <= 1'b0;
      wb_q   <= '0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      md_opA <= opa_nxt;
      md_opB <= opb_nxt;
      rd_q   <= rd_nxt;
      armed  <= armed_nxt;
      wb_q   <= wb_nxt;
    end
  end

  // armed masks the unit's stale ready during the first BUSY cycle.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    opa_nxt   = md_opA;
    opb_nxt   = md_opB;
    rd_nxt    = rd_q;
    armed_nxt = armed;
    wb_nxt    = wb_q;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (detect) begin
            state_nxt = ST_ISSUE;
            op_nxt    = x_is_mult ? OP_MULT : OP_DIV;
            opa_nxt   = x_opA;
            opb_nxt   = x_opB;
            rd_nxt    = x_rd;
          end
        end
        ST_ISSUE: begin
          state_nxt = ST_BUSY;
          armed_nxt = 1'b0;
        end
        ST_BUSY: begin
          armed_nxt = 1'b1;
          if (armed && md_resultRDY) begin
            state_nxt = ST_DONE;
            if (md_exception) begin
              wb_nxt = exc_wb(op);
            end else begin
              wb_nxt.rd   = rd_q;
              wb_nxt.data = md_result;
              wb_nxt.exc  = 1'b0;
            end
          end else if (wd_tc_c) begin
            state_nxt = ST_DONE;
            wb_nxt    = exc_wb(op);
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign md_ctrl_mult = (state == ST_ISSUE) & (op == OP_MULT);
  assign md_ctrl_div  = (state == ST_ISSUE) & (op == OP_DIV);

  // Detection-cycle stall must be combinational so X freezes immediately.
  assign stall = ~reset & (((state == ST_IDLE) & detect) |
                           (state == ST_ISSUE) | (state == ST_BUSY));

  assign wb_valid     = (state == ST_DONE) & ~abort;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign wb_exception = wb_q.exc;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: directed ops push expected
// writebacks, a negedge monitor pops and compares them.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        abort;
  logic        x_valid, x_is_mult, x_is_div;
  logic [31:0] x_opA, x_opB;
  logic [4:0]  x_rd;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_opA, md_opB;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        wd_ctrl_mult, wd_ctrl_div, wd_stall, wd_wb_valid, wd_wb_exception;
  logic [31:0] wd_opA, wd_opB, wd_wb_data;
  logic [4:0]  wd_wb_rd;
  logic        wd_rdy = 1'b0;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int last_t0 = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic        wd_armed = 1'b0;
  int          wd_cyc = -1;
  logic [37:0] wd_got = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_issue_ctrl #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .abort(abort),
    .x_valid(x_valid), .x_is_mult(x_is_mult), .x_is_div(x_is_div),
    .x_opA(x_opA), .x_opB(x_opB), .x_rd(x_rd),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception)
  );

  multdiv_issue_ctrl #(.TIMEOUT(8)) dut_wd (
    .clock(clock), .reset(reset), .abort(abort),
    .x_valid(x_valid), .x_is_mult(x_is_mult), .x_is_div(x_is_div),
    .x_opA(x_opA), .x_opB(x_opB), .x_rd(x_rd),
    .md_ctrl_mult(wd_ctrl_mult), .md_ctrl_div(wd_ctrl_div),
    .md_opA(wd_opA), .md_opB(wd_opB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(wd_rdy),
    .stall(wd_stall), .wb_valid(wd_wb_valid), .wb_rd(wd_wb_rd), .wb_data(wd_wb_data),
    .wb_exception(wd_wb_exception)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [105:0] outs();
    return {md_ctrl_mult, md_ctrl_div, md_opA, md_opB, stall, wb_valid,
            wb_rd, wb_data, wb_exception};
  endfunction

  // Writeback monitor: every wb_valid must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && wb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", {wb_rd, wb_data, wb_exception}, 128'h0);
        if (!wb_valid) nfail++;
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb", {wb_rd, wb_data, wb_exception, 32'(cyc)},
                  {e.rd, e.data, e.exc, 32'(e.cyc)});
      end
    end
  end

  always @(negedge clock) begin
    if (wd_armed && wd_wb_valid) begin
      wd_armed = 1'b0;
      wd_cyc   = cyc;
      wd_got   = {wd_wb_rd, wd_wb_data, wd_wb_exception};
    end
  end

  // Drives one op through the pipeline and models the unit's ready after k cycles.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int k,
                        input logic [31:0] res, input logic exc,
                        input bit no_rdy, input bit stale,
                        input logic [4:0] erd, input logic [31:0] edata,
                        input logic eexc);
    exp_t e;
    int t0;
    @(posedge clock); #1;
    x_valid = 1'b1; x_is_mult = m; x_is_div = d;
    x_opA = a; x_opB = b; x_rd = rd; md_result = res;
    t0 = cyc; last_t0 = t0;
    e.rd = erd; e.data = edata; e.exc = eexc; e.cyc = t0 + k + 2;
    q.push_back(e);
    for (int i = 0; i < k + 3; i++) begin
      if (!stale) begin
        md_resultRDY = (i == k + 1) && !no_rdy;
        md_exception = (i == k + 1) && exc;
      end
      @(negedge clock);
      chk("stall", stall, (i < k + 2));
      chk("start_pulse", {md_ctrl_mult, md_ctrl_div},
          {(i == 1) && m, (i == 1) && !m && d});
      if (i >= 1) chk("operands", {md_opA, md_opB}, {a, b});
      @(posedge clock); #1;
    end
    x_valid = 1'b0;
    if (!stale) begin
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
    end
    @(negedge clock);
    chk("no_reissue", {md_ctrl_mult, md_ctrl_div}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0;
    x_valid = 1'b0; x_is_mult = 1'b0; x_is_div = 1'b0;
    x_opA = '0; x_opB = '0; x_rd = '0;
    md_result = 32'd14; md_exception = 1'b0; md_resultRDY = 1'b1;

    @(negedge clock);
    chk("reset_state", outs(), '0);
    @(posedge clock); #1 reset = 1'b0;

    // Ready stuck high from reset: 100/7 completes at T+4.
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 2, 32'd14, 1'b0, 1'b0, 1'b1,
           5'd3, 32'd14, 1'b0);
    md_resultRDY = 1'b0;

    // 7 * -3 with ready at K=16.
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 16, 32'hFFFF_FFEB, 1'b0,
           1'b0, 1'b0, 5'd5, 32'hFFFF_FFEB, 1'b0);

    // 9 / 0 raises an exception.
    run_op(1'b0, 1'b1, 32'd9, 32'd0, 5'd7, 4, 32'd0, 1'b1, 1'b0, 1'b0,
           5'd30, 32'd5, 1'b1);

    // Abort in BUSY at T+6.
    @(posedge clock); #1;
    x_valid = 1'b1; x_is_mult = 1'b1; x_is_div = 1'b0;
    x_opA = 32'd11; x_opB = 32'd13; x_rd = 5'd9;
    repeat (6) @(posedge clock);
    #1 abort = 1'b1;
    @(negedge clock);
    chk("abort_cycle_stall", stall, 1'b1);
    @(posedge clock); #1;
    abort = 1'b0; x_valid = 1'b0;
    @(negedge clock);
    chk("after_abort", {stall, wb_valid, md_ctrl_mult, md_ctrl_div}, 4'b0000);
    repeat (3) @(negedge clock);

    run_op(1'b1, 1'b0, 32'd20, 32'd21, 5'd10, 3, 32'd420, 1'b0, 1'b0, 1'b0,
           5'd10, 32'd420, 1'b0);

    // Abort coincident with detection in IDLE: nothing is captured.
    @(posedge clock); #1;
    abort = 1'b1; x_valid = 1'b1; x_is_mult = 1'b0; x_is_div = 1'b1;
    x_opA = 32'd55; x_opB = 32'd66; x_rd = 5'd2;
    @(posedge clock); #1;
    abort = 1'b0; x_valid = 1'b0;
    @(negedge clock);
    chk("abort_idle", {md_ctrl_mult, md_ctrl_div, stall, md_opA},
        {1'b0, 1'b0, 1'b0, 32'd20});

    // Timeout: no ready ever; watchdog at 8 and at 64.
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    wd_armed = 1'b1;
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd12, 64, 32'd0, 1'b0, 1'b1, 1'b0,
           5'd30, 32'd4, 1'b1);
    chk("wd_timeout8", {wd_got, 32'(wd_cyc)}, {5'd30, 32'd4, 1'b1, 32'(last_t0 + 10)});

    // Async reset mid-BUSY, checked between edges.
    @(posedge clock); #1;
    x_valid = 1'b1; x_is_mult = 1'b1; x_is_div = 1'b0;
    x_opA = 32'd5; x_opB = 32'd6; x_rd = 5'd4;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), '0);
    x_valid = 1'b0;
    #1 reset = 1'b0;

    // Both decode bits set: mult takes priority.
    run_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd8, 5, 32'd42, 1'b0, 1'b0, 1'b0,
           5'd8, 32'd42, 1'b0);

    repeat (5) @(posedge clock);
    chk("pending_wb", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Sequencer that lets the 5-stage pipeline use the shared multi-cycle multdiv unit. When a mult or div sits in the execute stage, it freezes the front of the pipeline and pulses the unit's start control exactly once. It holds the operands stable for the whole operation, waits for ready, then emits one writeback: the product/quotient to rd, or the error code to $rstatus (r30) on exception.

## Interface
- TIMEOUT, 64: max cycles in BUSY before forced completion with exception.
- clock  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- abort  in  1  squash in-flight op (flush); synchronous.
- x_valid  in  1  execute-stage instruction valid.
- x_is_mult / x_is_div  in  1 each  decoded mul / div in execute.
- x_opA, x_opB  in  32 each  execute-stage operands.
- x_rd  in  5  destination register.
- md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses to multdiv.
- md_opA, md_opB  out  32 each  registered operands, held constant from ISSUE until next issue.
- md_result  in  32; md_exception  in  1; md_resultRDY  in  1  from multdiv.
- stall  out  1  freeze F/D/X stage registers.
- wb_valid  out  1; wb_rd  out  5; wb_data  out  32; wb_exception  out  1  writeback request, one cycle.

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE: on x_valid & (x_is_mult | x_is_div) → ISSUE.
  - Capture x_opA/x_opB into md_opA/md_opB, x_rd, and op kind (mult wins if both are set).
- ISSUE: assert md_ctrl_mult or md_ctrl_div for exactly this cycle; clear watchdog; → BUSY.
- BUSY: md_resultRDY is ignored in the first BUSY cycle; the unit's ready is stale around the start pulse.
  - From the second BUSY cycle, md_resultRDY=1 → capture md_result, md_exception; → DONE.
  - Watchdog reaching TIMEOUT → DONE with exception forced.
- DONE: wb_valid=1 for one cycle; → IDLE.
  - The instruction still visible in X during DONE is never re-issued.
- Writeback content:
  - No exception: wb_rd=captured rd, wb_data=md_result, wb_exception=0.
  - Exception or timeout: wb_rd=30, wb_data=4 for mult / 5 for div, wb_exception=1.
- Writes with rd=0 are still emitted; register-file suppression is not this block's job.
- stall = (IDLE & x_valid & (x_is_mult|x_is_div)) | ISSUE | BUSY. Combinational, so the detecting cycle already stalls. stall=0 in DONE.
- abort: any state → IDLE at next edge.
  - No start pulse in the abort cycle's successor; no wb_valid for the squashed op.
  - abort during DONE suppresses that cycle's wb_valid combinationally.
- Simultaneous abort and new detection in IDLE: abort wins, nothing captured.
- Non-mult/div instructions pass through untouched; stall=0 in IDLE for them.

## Timing
- Reset values: every output 0; md_opA/md_opB = 0; state IDLE.
- Detection cycle T: stall=1. T+1: ISSUE pulse. T+2 onward: BUSY.
- wb_valid occurs the cycle after RDY is sampled in BUSY.
- With ready K cycles after the pulse (K≥2): wb_valid at T+K+2. stall falls at T+K+2.
- Start pulse width is exactly 1; md_ctrl_mult & md_ctrl_div are never both high.
- Back-to-back mul/div: earliest next ISSUE is 2 cycles after DONE (DONE, IDLE detect, ISSUE).
- Reset mid-operation: outputs clear asynchronously; any pending writeback is lost.

## Structure
- Shared package/header holds:
  - state encoding (2 bits);
  - RSTATUS_REG=30;
  - EXC_MULT=4, EXC_DIV=5;
  - op-kind encoding.
- One sub-module: md_watchdog, a saturating counter with clear and terminal-count output, parameterised by TIMEOUT.
- The FSM, operand holding registers and writeback register stay in the top.

## Test plan
- Mult, no exception: 7 × (−3), model unit RDY at K=16 → one ctrl_mult pulse.
  - stall high T..T+17; wb_valid at T+18 with rd as given, data=0xFFFFFFEB, exc=0.
- Div by zero: 9 / 0, model raises md_exception → wb_rd=30, wb_data=5, wb_exception=1, single ctrl_div pulse.
- Stale ready: md_resultRDY held 1 continuously from reset → first BUSY cycle ignored; wb_valid exactly at T+4; operands held unchanged throughout.
- Abort in BUSY at T+6 → IDLE next cycle, stall drops, no wb_valid. A following mul then issues cleanly with fresh operands.
- Timeout: RDY never asserted, TIMEOUT=8 → wb_exception=1, wb_rd=30, wb_data=4 (mult) after 8 BUSY cycles.
- Async reset asserted mid-BUSY between edges → all outputs 0 immediately. After release, x_is_mult & x_is_div both high → only ctrl_mult pulses.
